// File: rtl/m68k_bus_master_if.sv
// 68000-style asynchronous bus as seen by the initiator (master) and a responder (slave).
// Groups address, strobes, data and DTACK so that bench drivers and responders share one bundle.
interface m68k_bus_master_if;
    logic [22:0] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic        RW;
    logic [15:0] DATA_OUT;
    logic        DATA_OE;
    logic [15:0] DATA_IN;
    logic        DTACK;

    modport master (
        output ADDR, AS_n, UDS_n, LDS_n, RW, DATA_OUT, DATA_OE,
        input  DATA_IN, DTACK
    );

    modport slave (
        input  ADDR, AS_n, UDS_n, LDS_n, RW, DATA_OUT, DATA_OE,
        output DATA_IN, DTACK
    );
endinterface

// File: rtl/m68k_bus_master.sv
// Single-word request/ack front end that runs one complete 68000 bus cycle (T1..REC),
// terminated by DTACK or by a wait-state timeout. All bus outputs are registered.
module m68k_bus_master #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                req,
    input  logic [22:0]         req_addr,
    input  logic                req_write,
    input  logic                req_uds,
    input  logic                req_lds,
    input  logic [15:0]         req_wdata,
    output logic                busy,
    output logic                ack,
    output logic                err,
    output logic [15:0]         rdata,
    m68k_bus_master_if.master   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_T1    = 3'd1;
    localparam logic [2:0] S_T2    = 3'd2;
    localparam logic [2:0] S_T3    = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_LATCH = 3'd5;
    localparam logic [2:0] S_END   = 3'd6;
    localparam logic [2:0] S_REC   = 3'd7;

    // Last counter value seen in WAIT before giving up (unused when TIMEOUT is 0).
    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

    logic [2:0]           state;
    logic                 wr_q;
    logic                 uds_q;
    logic                 lds_q;
    logic [15:0]          wdata_q;
    logic [TIMEOUT_W-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            ack          <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            wr_q         <= 1'b0;
            uds_q        <= 1'b0;
            lds_q        <= 1'b0;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            bus.ADDR     <= '0;
            bus.AS_n     <= 1'b1;
            bus.UDS_n    <= 1'b1;
            bus.LDS_n    <= 1'b1;
            bus.RW       <= 1'b1;
            bus.DATA_OUT <= '0;
            bus.DATA_OE  <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        wr_q    <= req_write;
                        uds_q   <= req_uds;
                        lds_q   <= req_lds;
                        wdata_q <= req_wdata;
                        busy    <= 1'b1;
                        // No lane enabled: report the error without touching the bus.
                        if (!req_uds && !req_lds) begin
                            state <= S_END;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= S_T1;
                            bus.ADDR <= req_addr;
                            bus.RW   <= !req_write;
                        end
                    end
                end
                S_T1: begin
                    state    <= S_T2;
                    bus.AS_n <= 1'b0;
                    if (wr_q) begin
                        bus.DATA_OE  <= 1'b1;
                        bus.DATA_OUT <= wdata_q;
                    end else begin
                        bus.UDS_n <= !uds_q;
                        bus.LDS_n <= !lds_q;
                    end
                end
                S_T2: begin
                    state <= S_T3;
                    // Write strobes trail AS_n by a cycle so data is settled first.
                    if (wr_q) begin
                        bus.UDS_n <= !uds_q;
                        bus.LDS_n <= !lds_q;
                    end
                end
                S_T3: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (bus.DTACK) begin
                        state    <= S_LATCH;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                        if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                            state     <= S_END;
                            ack       <= 1'b1;
                            err       <= 1'b1;
                            bus.AS_n  <= 1'b1;
                            bus.UDS_n <= 1'b1;
                            bus.LDS_n <= 1'b1;
                            if (!wr_q) rdata <= '0;
                        end
                    end
                end
                S_LATCH: begin
                    state     <= S_END;
                    ack       <= 1'b1;
                    bus.AS_n  <= 1'b1;
                    bus.UDS_n <= 1'b1;
                    bus.LDS_n <= 1'b1;
                    if (!wr_q) rdata <= bus.DATA_IN;
                end
                S_END: begin
                    state       <= S_REC;
                    bus.RW      <= 1'b1;
                    bus.DATA_OE <= 1'b0;
                end
                S_REC: begin
                    // Hold off until the responder releases DTACK from this cycle.
                    if (!bus.DTACK) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
